// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like memory port arbiter.
// Holds owner ID encodings, grant FSM state encodings, bus widths and the
// packed request payload forwarded to the memory slave.
package sram_like_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    // Owner IDs stored in the outstanding-transaction FIFO
    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    // Fetches are always full-word reads
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD_I = 2'd1,
        ST_HOLD_D = 2'd2
    } arb_state_e;

    // Request payload muxed onto the memory port
    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Hold state that pins the grant on the given owner
    function automatic arb_state_e hold_state(input logic id);
        return (id == ARB_ID_DATA) ? ST_HOLD_D : ST_HOLD_I;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// arb_id_fifo: in-order FIFO of 1-bit owner IDs for accepted transactions.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_id     enqueue an owner ID
//   pop               dequeue the head
//   full, empty       occupancy flags
//   head              owner ID at the head (registered storage)
// Push while full and pop while empty are ignored.
module arb_id_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == CW'(0));
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage, pointers (wrap naturally for power-of-two depth) and count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: 2:1 arbiter sharing one SRAM-like memory port between
// instruction fetch (inst_*) and the data path (data_*).
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   inst_req/addr -> inst_addr_ok   fetch request side
//   inst_rdata, inst_data_ok        fetch response side
//   data_req/wr/size/addr/wdata     data request side, data_addr_ok accept
//   data_rdata, data_data_ok        data response side
//   m_req/wr/size/addr/wdata        request to memory slave, m_addr_ok accept
//   m_rdata, m_data_ok              slave response (in request order)
// Request and response paths are combinational (zero latency); owner of each
// accepted request is queued in arb_id_fifo to steer responses.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-break in IDLE;
// otherwise data has fixed priority over fetch.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,
    output logic              m_req,
    output logic              m_wr,
    output logic [SIZE_W-1:0] m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_data_ok
);

    arb_state_e state;
    arb_state_e next_state;
    logic       grant;
    logic       winner;
    logic       req_c;
    logic       handshake;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       pop;
    mem_req_t   inst_pl;
    mem_req_t   data_pl;
    mem_req_t   sel_pl;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner;

    // Remember who won the last handshake; reset to data so fetch wins first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_winner <= ARB_ID_DATA;
        end else if (handshake) begin
            last_winner <= grant;
        end
    end
`endif

    // IDLE winner selection
    always_comb begin
        winner = ARB_ID_INST;
        if (data_req && !inst_req) begin
            winner = ARB_ID_DATA;
        end else if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = ~last_winner;
`else
            winner = ARB_ID_DATA;
`endif
        end
    end

    // Grant state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, grant and raw request; a full FIFO freezes the FSM
    always_comb begin
        next_state = state;
        grant      = ARB_ID_INST;
        req_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                grant = winner;
                if (!fifo_full && (inst_req || data_req)) begin
                    req_c = 1'b1;
                    if (!m_addr_ok) begin
                        next_state = hold_state(winner);
                    end
                end
            end
            ST_HOLD_I: begin
                grant = ARB_ID_INST;
                if (!fifo_full) begin
                    req_c = inst_req;
                    if (!inst_req || m_addr_ok) begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_HOLD_D: begin
                grant = ARB_ID_DATA;
                if (!fifo_full) begin
                    req_c = data_req;
                    if (!data_req || m_addr_ok) begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Payload mux; fetch forwards a word read with zero store data
    always_comb begin
        inst_pl       = '0;
        inst_pl.wr    = 1'b0;
        inst_pl.size  = SIZE_WORD;
        inst_pl.addr  = inst_addr;
        inst_pl.wdata = '0;
        data_pl       = '0;
        data_pl.wr    = data_wr;
        data_pl.size  = data_size;
        data_pl.addr  = data_addr;
        data_pl.wdata = data_wdata;
        sel_pl        = (grant == ARB_ID_DATA) ? data_pl : inst_pl;
    end

    // Reset forces the request low even though it is combinational from inputs
    assign m_req     = req_c && !reset;
    assign m_wr      = sel_pl.wr;
    assign m_size    = sel_pl.size;
    assign m_addr    = sel_pl.addr;
    assign m_wdata   = sel_pl.wdata;
    assign handshake = m_req && m_addr_ok;

    assign inst_addr_ok = handshake && (grant == ARB_ID_INST);
    assign data_addr_ok = handshake && (grant == ARB_ID_DATA);

    // Responses with nothing outstanding are dropped
    assign pop          = m_data_ok && !fifo_empty;
    assign inst_data_ok = pop && (fifo_head == ARB_ID_INST);
    assign data_data_ok = pop && (fifo_head == ARB_ID_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    arb_id_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (handshake),
        .push_id (grant),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter (OUTSTANDING_DEPTH=4).
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic [31:0] m_rdata;
    logic        m_data_ok;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_rdata      (m_rdata),
        .m_data_ok    (m_data_ok)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        m_addr_ok  = 1'b0;
        m_rdata    = 32'h0;
        m_data_ok  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_inputs();
        inst_req  = 1'b1;
        data_req  = 1'b1;
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        settle();
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset_m_req got=%b exp=0", m_req); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL reset_addr_ok got=%b exp=00", {inst_addr_ok, data_addr_ok}); end
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL reset_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.state); end
        tick();
        reset = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_single_fetch;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        m_addr_ok = 1'b1;
        settle();
        checks++; if (m_req !== 1'b1 || m_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL fetch_req got=%b/%h exp=1/bfc00000", m_req, m_addr); end
        checks++; if (m_wr !== 1'b0 || m_size !== 2'd2 || m_wdata !== 32'h0) begin failures++; $display("FAIL fetch_fields got=%b/%0d/%h exp=0/2/0", m_wr, m_size, m_wdata); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("FAIL fetch_addr_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
        tick();
        inst_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'h3C01_0000;
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL fetch_data_ok got=%b exp=10", {inst_data_ok, data_data_ok}); end
        checks++; if (inst_rdata !== 32'h3C01_0000) begin failures++; $display("FAIL fetch_rdata got=%h exp=3c010000", inst_rdata); end
        checks++; if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL fetch_addr_ok_once got=%b exp=0", inst_addr_ok); end
        tick();
        clear_inputs();
        settle();
        checks++; if (dut.u_fifo.count !== 3'd0) begin failures++; $display("FAIL fetch_count got=%0d exp=0", dut.u_fifo.count); end
        tick();
    endtask

`ifndef ARB_ROUND_ROBIN_EN
    task automatic test_priority;
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0100;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_addr  = 32'h0000_0200;
        data_wdata = 32'hDEAD_BEEF;
        m_addr_ok  = 1'b1;
        settle();
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin failures++; $display("FAIL prio_first got=%b exp=01", {inst_addr_ok, data_addr_ok}); end
        checks++; if (m_addr !== 32'h200 || m_wr !== 1'b1 || m_size !== 2'd1 || m_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL prio_data_fields got=%h/%b/%0d/%h exp=200/1/1/deadbeef", m_addr, m_wr, m_size, m_wdata); end
        tick();
        data_req = 1'b0;
        settle();
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || m_addr !== 32'h100 || m_wdata !== 32'h0) begin failures++; $display("FAIL prio_second got=%b/%h/%h exp=10/100/0", {inst_addr_ok, data_addr_ok}, m_addr, m_wdata); end
        tick();
        inst_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'h1111_1111;
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h11111111) begin failures++; $display("FAIL prio_resp1 got=%b/%h exp=01/11111111", {inst_data_ok, data_data_ok}, data_rdata); end
        tick();
        m_rdata = 32'h2222_2222;
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h22222222) begin failures++; $display("FAIL prio_resp2 got=%b/%h exp=10/22222222", {inst_data_ok, data_data_ok}, inst_rdata); end
        tick();
        clear_inputs();
    endtask
`endif

    task automatic test_hold;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0300;
        settle();
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h300) begin failures++; $display("FAIL hold_c1 got=%b/%h exp=1/300", m_req, m_addr); end
        tick();
        data_req  = 1'b1;
        data_addr = 32'h0000_0400;
        settle();
        checks++; if (dut.state !== ST_HOLD_I || m_addr !== 32'h300 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL hold_c2 got=%0d/%h/%b exp=1/300/0", dut.state, m_addr, data_addr_ok); end
        tick();
        settle();
        checks++; if (dut.state !== ST_HOLD_I || m_addr !== 32'h300) begin failures++; $display("FAIL hold_c3 got=%0d/%h exp=1/300", dut.state, m_addr); end
        tick();
        m_addr_ok = 1'b1;
        settle();
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || m_addr !== 32'h300) begin failures++; $display("FAIL hold_accept got=%b/%h exp=10/300", {inst_addr_ok, data_addr_ok}, m_addr); end
        tick();
        inst_req = 1'b0;
        settle();
        checks++; if (dut.state !== ST_IDLE || data_addr_ok !== 1'b1 || m_addr !== 32'h400) begin failures++; $display("FAIL hold_then_data got=%0d/%b/%h exp=0/1/400", dut.state, data_addr_ok, m_addr); end
        tick();
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL hold_resp1 got=%b exp=10", {inst_data_ok, data_data_ok}); end
        tick();
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL hold_resp2 got=%b exp=01", {inst_data_ok, data_data_ok}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_full;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_1000;
        m_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL full_accept%0d got=%b exp=1", i, inst_addr_ok); end
            tick();
        end
        settle();
        checks++; if (m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL full_block got=%b/%b exp=0/0", m_req, inst_addr_ok); end
        checks++; if (dut.u_fifo.count !== 3'd4 || dut.state !== ST_IDLE) begin failures++; $display("FAIL full_count got=%0d/%0d exp=4/0", dut.u_fifo.count, dut.state); end
        tick();
        m_data_ok = 1'b1;
        settle();
        checks++; if (m_req !== 1'b0 || inst_data_ok !== 1'b1) begin failures++; $display("FAIL full_pop_cycle got=%b/%b exp=0/1", m_req, inst_data_ok); end
        tick();
        m_data_ok = 1'b0;
        settle();
        checks++; if (m_req !== 1'b1 || inst_addr_ok !== 1'b1) begin failures++; $display("FAIL full_reassert got=%b/%b exp=1/1", m_req, inst_addr_ok); end
        tick();
        inst_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL full_drain%0d got=%b exp=1", i, inst_data_ok); end
            tick();
        end
        clear_inputs();
        settle();
        checks++; if (dut.u_fifo.count !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", dut.u_fifo.count); end
        tick();
    endtask

    task automatic test_push_pop;
        data_req  = 1'b1;
        data_addr = 32'h0000_2000;
        m_addr_ok = 1'b1;
        settle();
        checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL pp_push_d got=%b exp=1", data_addr_ok); end
        tick();
        data_req  = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_3000;
        settle();
        checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL pp_push_i got=%b exp=1", inst_addr_ok); end
        tick();
        inst_req  = 1'b0;
        data_req  = 1'b1;
        m_data_ok = 1'b1;
        settle();
        checks++; if (dut.u_fifo.count !== 3'd2) begin failures++; $display("FAIL pp_count_before got=%0d exp=2", dut.u_fifo.count); end
        checks++; if ({data_addr_ok, inst_data_ok, data_data_ok} !== 3'b101) begin failures++; $display("FAIL pp_same_cycle got=%b exp=101", {data_addr_ok, inst_data_ok, data_data_ok}); end
        tick();
        clear_inputs();
        settle();
        checks++; if (dut.u_fifo.count !== 3'd2) begin failures++; $display("FAIL pp_count_after got=%0d exp=2", dut.u_fifo.count); end
        tick();
        m_data_ok = 1'b1;
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL pp_resp_i got=%b exp=10", {inst_data_ok, data_data_ok}); end
        tick();
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL pp_resp_d got=%b exp=01", {inst_data_ok, data_data_ok}); end
        tick();
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL pp_spurious got=%b exp=00", {inst_data_ok, data_data_ok}); end
        tick();
        clear_inputs();
        settle();
        checks++; if (dut.u_fifo.count !== 3'd0) begin failures++; $display("FAIL pp_spurious_count got=%0d exp=0", dut.u_fifo.count); end
        tick();
    endtask

    task automatic test_reset_mid;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_4000;
        m_addr_ok = 1'b1;
        tick();
        tick();
        tick();
        settle();
        checks++; if (dut.u_fifo.count !== 3'd3) begin failures++; $display("FAIL rst_mid_fill got=%0d exp=3", dut.u_fifo.count); end
        tick();
        reset = 1'b1;
        settle();
        checks++; if (dut.u_fifo.count !== 3'd0 || m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL rst_mid_clear got=%0d/%b/%b exp=0/0/0", dut.u_fifo.count, m_req, inst_addr_ok); end
        tick();
        reset = 1'b0;
        clear_inputs();
        m_data_ok = 1'b1;
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL rst_mid_late got=%b exp=00", {inst_data_ok, data_data_ok}); end
        tick();
        clear_inputs();
        settle();
        checks++; if (dut.u_fifo.count !== 3'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", dut.u_fifo.count); end
        tick();
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    task automatic test_round_robin;
        logic [1:0] exp_ok [3];
        exp_ok[0] = 2'b10;
        exp_ok[1] = 2'b01;
        exp_ok[2] = 2'b10;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_5000;
        data_req  = 1'b1;
        data_addr = 32'h0000_6000;
        m_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if ({inst_addr_ok, data_addr_ok} !== exp_ok[i]) begin failures++; $display("FAIL rr_tie%0d got=%b exp=%b", i, {inst_addr_ok, data_addr_ok}, exp_ok[i]); end
            tick();
        end
        clear_inputs();
        m_data_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if ({inst_data_ok, data_data_ok} !== exp_ok[i]) begin failures++; $display("FAIL rr_resp%0d got=%b exp=%b", i, {inst_data_ok, data_data_ok}, exp_ok[i]); end
            tick();
        end
        clear_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
`ifndef ARB_ROUND_ROBIN_EN
        test_priority();
`endif
        test_hold();
        test_full();
        test_push_pop();
        test_reset_mid();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
